sar_search_8bit: RTL and testbench

Successive-approximation search controller: the driving end of the 8-bit magnitude comparator. It issues trial values on the comparator's `a` input and consumes the comparator's `A_GT_B`/`A_LT_B`/`A_EQ_B` flags, binary-searching until it finds the unknown value on the comparator's `b` input. It sits beside `comp_8bit` in the ALU datapath, where the comparator's `b` port is driven by the target. It serves as the shared engine for SAR-style conversion and value lookup.

---
 rtl/sar_search_8bit_if.sv | 27 ++
 rtl/sar_search_8bit.sv | 119 +++++++++++
 tb/tb_sar_search_8bit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_8bit_if.sv
// Bus between the successive-approximation search controller and its user/comparator side.
// The slave end is the controller; the master end starts searches and supplies comparator flags.
interface sar_search_8bit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] trial;
  logic             A_GT_B;
  logic             A_LT_B;
  logic             A_EQ_B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;
  logic [3:0]       steps;

  modport master (
    output start, A_GT_B, A_LT_B, A_EQ_B,
    input  trial, busy, done, result, found, err, steps
  );

  modport slave (
    input  start, A_GT_B, A_LT_B, A_EQ_B,
    output trial, busy, done, result, found, err, steps
  );
endinterface

// File: rtl/sar_search_8bit.sv
// Successive-approximation search controller driving a magnitude comparator's `a` input.
// Optional feature macro SAR_SETTLE_EN inserts a SETTLE cycle before every COMPARE.
module sar_search_8bit #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  sar_search_8bit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd3
`ifdef SAR_SETTLE_EN
    , SETTLE = 2'd2
`endif
  } state_t;

  state_t state, nxt;

`ifdef SAR_SETTLE_EN
  localparam state_t TRIAL_ST = SETTLE;
`else
  localparam state_t TRIAL_ST = COMPARE;
`endif

  localparam logic [WIDTH:0]   HI_INIT    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   ONE        = (WIDTH+1)'(1);

  // Bounds carry one extra bit so trial-1 at 0 and trial+1 at max cannot wrap into range.
  logic [WIDTH:0]   lo, hi;
  logic [WIDTH-1:0] trial_q, result_q;
  logic             found_q, err_q;
  logic [3:0]       steps_q;

  logic [WIDTH:0] trial_ext, hi_dec, lo_inc, sum_gt, sum_lt;
  logic           gt_only, lt_only, eq_only, cmp_stop, cmp_err;

  always_comb begin
    trial_ext = {1'b0, trial_q};
    hi_dec    = trial_ext - ONE;
    lo_inc    = trial_ext + ONE;
    sum_gt    = lo + hi_dec;
    sum_lt    = lo_inc + hi;
    gt_only   = ({bus.A_GT_B, bus.A_LT_B, bus.A_EQ_B} == 3'b100);
    lt_only   = ({bus.A_GT_B, bus.A_LT_B, bus.A_EQ_B} == 3'b010);
    eq_only   = ({bus.A_GT_B, bus.A_LT_B, bus.A_EQ_B} == 3'b001);
    // Non-one-hot flags or a bound about to cross both end the search with an error.
    cmp_stop  = eq_only
              | (gt_only & (trial_ext == lo))
              | (lt_only & (trial_ext == hi))
              | ~(gt_only | lt_only | eq_only);
    cmp_err   = cmp_stop & ~eq_only;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = TRIAL_ST;
`ifdef SAR_SETTLE_EN
      SETTLE:  nxt = COMPARE;
`endif
      COMPARE: nxt = cmp_stop ? DONE : TRIAL_ST;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != IDLE) && (state != DONE);
    bus.done   = (state == DONE);
    bus.trial  = trial_q;
    bus.result = result_q;
    bus.found  = found_q;
    bus.err    = err_q;
    bus.steps  = steps_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo       <= '0;
      hi       <= '0;
      trial_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      steps_q  <= 4'd0;
    end else if ((state == IDLE) && bus.start) begin
      lo       <= '0;
      hi       <= HI_INIT;
      trial_q  <= TRIAL_INIT;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      steps_q  <= 4'd0;
    end else if (state == COMPARE) begin
      if (steps_q != 4'd15) steps_q <= steps_q + 4'd1;
      if (cmp_stop) begin
        result_q <= trial_q;
        found_q  <= eq_only;
        err_q    <= cmp_err;
      end else if (gt_only) begin
        hi      <= hi_dec;
        trial_q <= WIDTH'(sum_gt >> 1);
      end else begin
        lo      <= lo_inc;
        trial_q <= WIDTH'(sum_lt >> 1);
      end
    end
  end

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit with a behavioural comparator and forced-flag override.
module tb_sar_search_8bit;

`ifdef SAR_SETTLE_EN
  localparam bit SETTLE = 1'b1;
`else
  localparam bit SETTLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   target = 0;
  bit   force_en = 1'b0;
  logic [2:0] force_flags = 3'b000;

  int checks = 0;
  int errors = 0;
  int trials[$];
  int busy_done_overlap = 0;

  sar_search_8bit_if #(.WIDTH(8)) bus ();

  sar_search_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (force_en) begin
      {bus.A_GT_B, bus.A_LT_B, bus.A_EQ_B} = force_flags;
    end else begin
      bus.A_GT_B = (int'(bus.trial) > target);
      bus.A_LT_B = (int'(bus.trial) < target);
      bus.A_EQ_B = (int'(bus.trial) == target);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int done_at(input int n);
    return SETTLE ? 2 * n + 1 : n + 1;
  endfunction

  task automatic launch(input int tgt);
    target = tgt;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Follows a running search from cycle 1; optionally re-pulses start in cycles 2..4 or
  // raises start at the done cycle so the following IDLE cycle accepts a new search.
  task automatic wait_done(input bit repulse, input bit hold_after,
                           output int done_cyc, output int ndone);
    done_cyc = 0;
    ndone = 0;
    trials.delete();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (repulse) bus.start = (k >= 2 && k <= 4);
      if (bus.busy && (!SETTLE || (k % 2 == 0))) trials.push_back(int'(bus.trial));
      if (bus.busy && bus.done) busy_done_overlap++;
      if (bus.done) begin
        ndone++;
        if (done_cyc == 0) done_cyc = k;
        if (hold_after) begin
          bus.start = 1'b1;
          return;
        end
      end
      if (done_cyc != 0 && k >= done_cyc + 3) break;
    end
    if (repulse) bus.start = 1'b0;
    if (done_cyc == 0) check("timeout_done", 0, 1);
  endtask

  task automatic check_trials(input string tag, input int exp[]);
    check({tag, "_ntrials"}, trials.size(), exp.size());
    for (int i = 0; i < exp.size() && i < trials.size(); i++)
      check({tag, "_trial"}, trials[i], exp[i]);
  endtask

  initial begin
    int dc, nd;
    bus.start = 1'b0;

    #12;
    check("rst_trial", int'(bus.trial), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_steps", int'(bus.steps), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    launch(127);
    wait_done(1'b0, 1'b0, dc, nd);
    check_trials("t127", '{127});
    check("t127_found", int'(bus.found), 1);
    check("t127_result", int'(bus.result), 127);
    check("t127_steps", int'(bus.steps), 1);
    check("t127_donecyc", dc, done_at(1));
    check("t127_ndone", nd, 1);

    launch(0);
    wait_done(1'b0, 1'b0, dc, nd);
    check_trials("t0", '{127, 63, 31, 15, 7, 3, 1, 0});
    check("t0_found", int'(bus.found), 1);
    check("t0_steps", int'(bus.steps), 8);
    check("t0_err", int'(bus.err), 0);
    check("t0_result", int'(bus.result), 0);

    launch(255);
    wait_done(1'b0, 1'b0, dc, nd);
    check_trials("t255", '{127, 191, 223, 239, 247, 251, 253, 254, 255});
    check("t255_steps", int'(bus.steps), 9);
    check("t255_found", int'(bus.found), 1);
    check("t255_donecyc", dc, done_at(9));
    check("t255_hold_trial", int'(bus.trial), 255);

    force_en = 1'b1;
    force_flags = 3'b000;
    launch(50);
    wait_done(1'b0, 1'b0, dc, nd);
    check("f000_err", int'(bus.err), 1);
    check("f000_found", int'(bus.found), 0);
    check("f000_steps", int'(bus.steps), 1);
    check("f000_result", int'(bus.result), 127);
    check("f000_donecyc", dc, done_at(1));

    force_flags = 3'b110;
    launch(50);
    wait_done(1'b0, 1'b0, dc, nd);
    check("f110_err", int'(bus.err), 1);
    check("f110_found", int'(bus.found), 0);
    check("f110_steps", int'(bus.steps), 1);
    check("f110_result", int'(bus.result), 127);
    force_en = 1'b0;

    // Reset in cycle 3 of a search for 30 must clear everything at once.
    launch(30);
    nd = 0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_trial", int'(bus.trial), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_steps", int'(bus.steps), 0);
    check("arst_result", int'(bus.result), 0);
    check("arst_found", int'(bus.found), 0);
    check("arst_err", int'(bus.err), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) nd++;
      if (k == 3) rst_n = 1'b1;
    end
    check("arst_nodone", nd, 0);
    launch(30);
    wait_done(1'b0, 1'b0, dc, nd);
    check("t30_result", int'(bus.result), 30);
    check("t30_found", int'(bus.found), 1);
    check("t30_steps", int'(bus.steps), 8);

    launch(8);
    wait_done(1'b1, 1'b0, dc, nd);
    check_trials("t8", '{127, 63, 31, 15, 7, 11, 9, 8});
    check("t8_ndone", nd, 1);
    check("t8_result", int'(bus.result), 8);
    check("t8_donecyc", dc, done_at(8));

    // Back-to-back: start held from the done cycle through the following IDLE cycle.
    launch(8);
    wait_done(1'b0, 1'b1, dc, nd);
    check("b2b_first_result", int'(bus.result), 8);
    target = 200;
    @(negedge clk);
    check("b2b_idle_busy", int'(bus.busy), 0);
    check("b2b_idle_done", int'(bus.done), 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(1'b0, 1'b0, dc, nd);
    check("b2b_second_result", int'(bus.result), 200);
    check("b2b_second_found", int'(bus.found), 1);
    check("b2b_second_ndone", nd, 1);

    check("busy_done_overlap", busy_done_overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
